// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotation/vectoring blocks.
package cordic_pkg;

  // Angle accumulator and output width (Q2.13 two's complement).
  localparam int ZW = 16;
  // Largest supported number of micro-rotations; also the atan table depth.
  localparam int ITER_MAX = 14;
  // Width of the iteration index.
  localparam int IW = 4;
  // Q2.13 value of one input angle LSB (pi/64 rad).
  localparam int ANG_SCALE = 402;
  // Q2.13 gain compensation 0.607253, preloaded into x.
  localparam int K_INIT = 4975;

  // atan(2^-i) in Q2.13 for i = 0..13.
  localparam logic [ZW-1:0] ATAN_LUT [ITER_MAX] = '{
    16'd6434, 16'd3798, 16'd2007, 16'd1019, 16'd511, 16'd256, 16'd128,
    16'd64,   16'd32,   16'd16,   16'd8,    16'd4,   16'd2,   16'd1
  };

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StDone
  } state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational index-to-atan lookup, shared by the CORDIC engines.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [IW-1:0] idx,
  output logic [ZW-1:0] atan
);

  // Indices past the table read as zero so a spare counter value is harmless.
  always_comb begin
    atan = '0;
    if (idx < IW'(ITER_MAX)) begin
      atan = ATAN_LUT[idx];
    end
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotation engine: one 6-bit angle in, Q2.13 cos/sin out.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 14
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    angle_in,
  output logic          out_valid,
  output logic          busy,
  output logic [ZW-1:0] cos_out,
  output logic [ZW-1:0] sin_out
);

  localparam logic signed [ZW-1:0] AngScaleZ = ZW'(ANG_SCALE);
  localparam logic signed [ZW-1:0] KInitZ    = ZW'(K_INIT);
  localparam logic [IW-1:0]        LastIter  = IW'(ITER - 1);

  state_e state_q, state_d;

  logic signed [ZW-1:0] x_q, x_d;
  logic signed [ZW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [IW-1:0]        iter_q, iter_d;

  logic [ZW-1:0]        atan;
  logic signed [ZW-1:0] atan_s;
  logic signed [ZW-1:0] ang_ext;
  logic signed [ZW-1:0] z_init;
  logic signed [ZW-1:0] x_sh;
  logic signed [ZW-1:0] y_sh;
  logic                 dir_pos;
  logic                 last_iter;

  cordic_atan_rom u_atan_rom (
    .idx  (iter_q),
    .atan (atan)
  );

  assign atan_s    = $signed(atan);
  assign ang_ext   = ZW'($signed(angle_in));
  // Exact for -32..31: the product stays within +/-12864.
  assign z_init    = ang_ext * AngScaleZ;
  assign x_sh      = x_q >>> iter_q;
  assign y_sh      = y_q >>> iter_q;
  assign dir_pos   = ~z_q[ZW-1];
  assign last_iter = (iter_q == LastIter);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, rotate ITER cycles, one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRot;
      StRot:   if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake/status outputs decoded from the state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StRot:   busy     = 1'b1;
      StDone:  busy     = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Shift-add datapath: load on acceptance, one micro-rotation per ROT cycle.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    iter_d = iter_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d    = KInitZ;
          y_d    = '0;
          z_d    = z_init;
          iter_d = '0;
        end
      end
      StRot: begin
        if (dir_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_s;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_s;
        end
        iter_d = iter_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      iter_q <= iter_d;
    end
  end

  // Result registers: capture on leaving DONE and pulse out_valid alongside.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
    end else begin
      out_valid <= (state_q == StDone);
      if (state_q == StDone) begin
        cos_out <= x_q;
        sin_out <= y_q;
      end
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed self-checking bench for cordic_rotator.
module tb_cordic_rotator;

  localparam real PI = 3.14159265358979;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [5:0]         angle_in = '0;
  logic               out_valid;
  logic               busy;
  logic signed [15:0] cos_out;
  logic signed [15:0] sin_out;

  int checks = 0;
  int failures = 0;
  int unstable = 0;

  cordic_rotator #(.ITER(14)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .busy      (busy),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    logic ok;
    ok = ((obs - exp) <= 8) && ((exp - obs) <= 8);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d+-8", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one angle, wait for its result, check latency and output stability.
  task automatic do_angle(input int a);
    logic signed [15:0] c0, s0;
    int lat;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) break;
      step();
    end
    check("ready_wait", int'(in_ready), 1);
    c0 = cos_out;
    s0 = sin_out;
    in_valid = 1'b1;
    angle_in = 6'(a);
    step();
    in_valid = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      if (cos_out !== c0 || sin_out !== s0) unstable++;
      step();
    end
    check("latency", lat, 15);
  endtask

  initial begin
    int bad_ready;
    int bad_ov;
    int seen;
    int ec;
    int es;
    logic signed [15:0] held;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cos", int'(cos_out), 0);
    check("rst_sin", int'(sin_out), 0);
    RST_N = 1'b1;
    step();

    // Angle 0 and the pulse/hold behaviour after it.
    do_angle(0);
    check_near("a0_cos", int'(cos_out), 8192);
    check_near("a0_sin", int'(sin_out), 0);
    held = cos_out;
    step();
    check("ov_one_cycle", int'(out_valid), 0);
    check("cos_held", int'(cos_out), int'(held));

    do_angle(16);
    check_near("a16_cos", int'(cos_out), 5793);
    check_near("a16_sin", int'(sin_out), 5793);
    do_angle(-16);
    check_near("am16_cos", int'(cos_out), 5793);
    check_near("am16_sin", int'(sin_out), -5793);
    do_angle(-32);
    check_near("am32_cos", int'(cos_out), 0);
    check_near("am32_sin", int'(sin_out), -8192);
    do_angle(31);
    check_near("a31_cos", int'(cos_out), 402);
    check_near("a31_sin", int'(sin_out), 8182);

    // in_valid held high with angle 8: extra requests ignored while busy.
    in_valid = 1'b1;
    angle_in = 6'd8;
    step();
    bad_ready = 0;
    bad_ov = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (in_ready) bad_ready++;
      if (out_valid) bad_ov++;
    end
    check("hold_ready_low", bad_ready, 0);
    check("hold_no_early_ov", bad_ov, 0);
    step();
    check("hold_ov_at_15", int'(out_valid), 1);
    check("hold_ready_at_15", int'(in_ready), 1);
    check("hold_busy_at_15", int'(busy), 0);
    check_near("a8_cos", int'(cos_out), 7568);
    check_near("a8_sin", int'(sin_out), 3135);
    step();
    check("hold_reaccept_16", int'(busy), 1);
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    check("hold_second_result", seen, 1);

    // Reset in the middle of a rotation.
    step();
    in_valid = 1'b1;
    angle_in = 6'd16;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    RST_N = 1'b0;
    #1;
    check("mid_rst_cos", int'(cos_out), 0);
    check("mid_rst_sin", int'(sin_out), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ov", int'(out_valid), 0);
    step();
    step();
    RST_N = 1'b1;
    bad_ov = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid) bad_ov++;
    end
    check("mid_rst_no_ov", bad_ov, 0);
    do_angle(16);
    check_near("post_rst_cos", int'(cos_out), 5793);
    check_near("post_rst_sin", int'(sin_out), 5793);

    // Back-to-back sweep against ideal cos/sin.
    unstable = 0;
    for (int a = -32; a <= 31; a++) begin
      do_angle(a);
      ec = int'($cos(real'(a) * PI / 64.0) * 8192.0);
      es = int'($sin(real'(a) * PI / 64.0) * 8192.0);
      check_near("sweep_cos", int'(cos_out), ec);
      check_near("sweep_sin", int'(sin_out), es);
    end
    check("sweep_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
